// File: rtl/paula_audio_dmareq_if.sv
// Bus bundle between Agnus/register bus/audio channels and the audio DMA request block.
interface paula_audio_dmareq_if;
    logic        clk7_en;
    logic        strhor;
    logic [3:0]  dmaena;
    logic [7:0]  reg_address_in;
    logic [15:0] data_in;
    logic [3:0]  datreq;
    logic [3:0]  audio_dmal;
    logic [3:0]  audio_dmas;
    logic [3:0]  audint;

    modport master (
        output clk7_en, strhor, dmaena, reg_address_in, data_in, datreq,
        input  audio_dmal, audio_dmas, audint
    );

    modport slave (
        input  clk7_en, strhor, dmaena, reg_address_in, data_in, datreq,
        output audio_dmal, audio_dmas, audint
    );
endinterface

// File: rtl/paula_audio_dmareq.sv
// Per-channel audio DMA request generator: AUDxLEN word counting, one fetch per line,
// restart (dmas) at block start and block-start interrupt.
module paula_audio_dmareq #(
    parameter logic [8:0] AUDLEN_BASE = 9'h0A4,
    parameter logic [8:0] CH_STRIDE   = 9'h010
) (
    input  logic                  clk,
    input  logic                  reset,
    paula_audio_dmareq_if.slave   bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q   [4];
    state_t      state_d   [4];
    logic [15:0] len_q     [4];
    logic [15:0] len_d     [4];
    logic [16:0] cnt_q     [4];
    logic [16:0] cnt_d     [4];
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  restart_q, restart_d;
    logic [3:0]  dmal_q, dmal_d;
    logic [3:0]  dmas_q, dmas_d;
    logic [3:0]  audint_q, audint_d;

    function automatic logic [7:0] len_addr(input int unsigned n);
        logic [8:0] byte_addr;
        byte_addr = AUDLEN_BASE + CH_STRIDE * n[8:0];
        return byte_addr[8:1];
    endfunction

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        restart_d = restart_q;
        dmal_d    = dmal_q;
        dmas_d    = dmas_q;
        audint_d  = '0;

        for (int unsigned n = 0; n < 4; n++) begin
            if (bus.reg_address_in == len_addr(n))
                len_d[n] = bus.data_in;

            case (state_q[n])
                IDLE: begin
                    dmal_d[n]    = 1'b0;
                    dmas_d[n]    = 1'b0;
                    pending_d[n] = 1'b0;
                    restart_d[n] = 1'b0;
                    if (bus.dmaena[n]) begin
                        state_d[n]   = RUN;
                        pending_d[n] = 1'b1;
                        restart_d[n] = 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.dmaena[n]) begin
                        state_d[n]   = IDLE;
                        dmal_d[n]    = 1'b0;
                        dmas_d[n]    = 1'b0;
                        pending_d[n] = 1'b0;
                        restart_d[n] = 1'b0;
                    end else if (bus.strhor) begin
                        // datreq on the strobe cycle is folded into this line's fetch
                        if (pending_q[n] || bus.datreq[n]) begin
                            dmal_d[n]    = 1'b1;
                            dmas_d[n]    = restart_q[n];
                            pending_d[n] = 1'b0;
                            if (restart_q[n]) begin
                                cnt_d[n]    = ((len_q[n] == 16'd0) ? 17'h10000 : {1'b0, len_q[n]}) - 17'd1;
                                audint_d[n] = 1'b1;
                            end else begin
                                cnt_d[n] = cnt_q[n] - 17'd1;
                            end
                            restart_d[n] = (cnt_d[n] == 17'd0);
                        end else begin
                            dmal_d[n] = 1'b0;
                            dmas_d[n] = 1'b0;
                        end
                    end else if (bus.datreq[n]) begin
                        pending_d[n] = 1'b1;
                    end
                end
                default: state_d[n] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (bus.clk7_en) begin
            if (reset) begin
                state_q   <= '{default: IDLE};
                len_q     <= '{default: '0};
                cnt_q     <= '{default: '0};
                pending_q <= '0;
                restart_q <= '0;
                dmal_q    <= '0;
                dmas_q    <= '0;
                audint_q  <= '0;
            end else begin
                state_q   <= state_d;
                len_q     <= len_d;
                cnt_q     <= cnt_d;
                pending_q <= pending_d;
                restart_q <= restart_d;
                dmal_q    <= dmal_d;
                dmas_q    <= dmas_d;
                audint_q  <= audint_d;
            end
        end
    end

    assign bus.audio_dmal = dmal_q;
    assign bus.audio_dmas = dmas_q;
    assign bus.audint     = audint_q;
endmodule

// File: tb/tb_paula_audio_dmareq.sv
// Scoreboard bench for paula_audio_dmareq: directed line sequences plus a full 65536-word block.
module tb_paula_audio_dmareq;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    paula_audio_dmareq_if bus();

    paula_audio_dmareq #(
        .AUDLEN_BASE(9'h0A4),
        .CH_STRIDE  (9'h010)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        string       tag;
        logic [11:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {bus.audint, bus.audio_dmas, bus.audio_dmal};
    endfunction

    // One clk cycle; expected {audint,dmas,dmal} is queued with the stimulus and
    // popped once the edge has happened.
    task automatic tick(input logic s, input logic [3:0] d, input logic en,
                        input logic [7:0] a, input logic [15:0] dat,
                        input logic chk, input logic [11:0] exp, input string tag);
        exp_t e;
        bus.strhor         = s;
        bus.datreq         = d;
        bus.clk7_en        = en;
        bus.reg_address_in = a;
        bus.data_in        = dat;
        if (chk) begin
            e.tag = tag;
            e.val = exp;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.strhor         = 1'b0;
        bus.datreq         = 4'b0000;
        bus.clk7_en        = 1'b0;
        bus.reg_address_in = 8'h00;
        bus.data_in        = 16'h0000;
        if (chk) begin
            e = sb.pop_front();
            check_eq(e.tag, {20'd0, outs()}, {20'd0, e.val});
        end
    endtask

    // A line: strobe cycle, a gated cycle (strobe ignored), then a plain enabled cycle.
    task automatic line(input logic [3:0] ds, input logic [3:0] dm,
                        input logic [7:0] a, input logic [15:0] dat,
                        input logic [11:0] exp, input string tag);
        tick(1'b1, ds, 1'b1, a, dat, 1'b1, exp, tag);
        tick(1'b1, 4'b0000, 1'b0, 8'h00, 16'h0000, 1'b1, exp, {tag, "_hold"});
        tick(1'b0, dm, 1'b1, 8'h00, 16'h0000, 1'b1, exp & 12'h0FF, {tag, "_mid"});
    endtask

    task automatic wr_len(input int ch, input logic [15:0] v);
        logic [7:0] a;
        a = 8'h52 + 8'(ch * 8);
        tick(1'b0, 4'b0000, 1'b1, a, v, 1'b0, 12'h000, "");
    endtask

    initial begin
        int dmas_cnt, int_cnt, dmal_cnt, first_idx, last_idx;

        reset              = 1'b1;
        bus.clk7_en        = 1'b0;
        bus.strhor         = 1'b0;
        bus.dmaena         = 4'b0000;
        bus.reg_address_in = 8'h00;
        bus.data_in        = 16'h0000;
        bus.datreq         = 4'b0000;

        tick(1'b0, 4'b0000, 1'b1, 8'h00, 16'h0000, 1'b0, 12'h000, "");
        tick(1'b0, 4'b0000, 1'b1, 8'h00, 16'h0000, 1'b1, 12'h000, "reset");
        reset = 1'b0;

        // ch0, len 3: dmas on lines 1 and 4 only
        wr_len(0, 16'd3);
        bus.dmaena = 4'b0001;
        tick(1'b0, 4'b0000, 1'b1, 8'h00, 16'h0000, 1'b1, 12'h000, "t1_en");
        line(4'b0000, 4'b0001, 8'h00, 16'h0000, 12'h111, "t1_l1");
        line(4'b0000, 4'b0001, 8'h00, 16'h0000, 12'h001, "t1_l2");
        line(4'b0000, 4'b0001, 8'h00, 16'h0000, 12'h001, "t1_l3");
        line(4'b0000, 4'b0000, 8'h00, 16'h0000, 12'h111, "t1_l4");
        line(4'b0000, 4'b0000, 8'h00, 16'h0000, 12'h000, "t1_l5");

        // ch2: three datreq in a line collapse to a single fetch
        wr_len(2, 16'd5);
        bus.dmaena = 4'b0101;
        tick(1'b0, 4'b0000, 1'b1, 8'h00, 16'h0000, 1'b1, 12'h000, "t3_en");
        line(4'b0000, 4'b0100, 8'h00, 16'h0000, 12'h444, "t3_first");
        tick(1'b0, 4'b0100, 1'b1, 8'h00, 16'h0000, 1'b1, 12'h044, "t3_dreq2");
        tick(1'b0, 4'b0100, 1'b1, 8'h00, 16'h0000, 1'b1, 12'h044, "t3_dreq3");
        line(4'b0000, 4'b0000, 8'h00, 16'h0000, 12'h004, "t3_fetch");
        line(4'b0000, 4'b0000, 8'h00, 16'h0000, 12'h000, "t3_next");

        // ch3, len 1: restart every word; datreq on strobe; LEN write on a restarting strobe
        wr_len(3, 16'd1);
        bus.dmaena = 4'b1101;
        tick(1'b0, 4'b0000, 1'b1, 8'h00, 16'h0000, 1'b1, 12'h000, "t4_en");
        line(4'b0000, 4'b0000, 8'h00, 16'h0000, 12'h888, "t4_first");
        line(4'b1000, 4'b0000, 8'h6A, 16'd2,    12'h888, "t4_coinc");
        line(4'b1000, 4'b0000, 8'h00, 16'h0000, 12'h888, "t4_oldlen");
        line(4'b1000, 4'b0000, 8'h00, 16'h0000, 12'h008, "t4_newlen");
        line(4'b0000, 4'b0000, 8'h00, 16'h0000, 12'h000, "t4_idle");

        // ch0 disabled mid-line, then re-enabled
        line(4'b0000, 4'b0001, 8'h00, 16'h0000, 12'h000, "t5_pre");
        line(4'b0000, 4'b0000, 8'h00, 16'h0000, 12'h001, "t5_fetch");
        bus.dmaena = 4'b1100;
        tick(1'b0, 4'b0000, 1'b0, 8'h00, 16'h0000, 1'b1, 12'h001, "t5_dis_gated");
        tick(1'b0, 4'b0000, 1'b1, 8'h00, 16'h0000, 1'b1, 12'h000, "t5_dis");
        bus.dmaena = 4'b1101;
        tick(1'b0, 4'b0000, 1'b1, 8'h00, 16'h0000, 1'b1, 12'h000, "t5_reen_idle");
        line(4'b0000, 4'b0000, 8'h00, 16'h0000, 12'h111, "t5_reen");

        // reset while channels are fetching; AUD1LEN gets a value that reset must clear
        wr_len(1, 16'd7);
        line(4'b0000, 4'b1101, 8'h00, 16'h0000, 12'h000, "t6_arm");
        line(4'b0000, 4'b0000, 8'h00, 16'h0000, 12'h88D, "t6_run");
        reset = 1'b1;
        tick(1'b0, 4'b0000, 1'b0, 8'h00, 16'h0000, 1'b1, 12'h08D, "t6_rst_gated");
        tick(1'b0, 4'b0000, 1'b1, 8'h00, 16'h0000, 1'b1, 12'h000, "t6_rst");
        reset      = 1'b0;
        bus.dmaena = 4'b0000;
        tick(1'b0, 4'b0000, 1'b1, 8'h00, 16'h0000, 1'b1, 12'h000, "t6_after");

        // ch1 with len 0 after reset: a block is 65536 words
        bus.dmaena = 4'b0010;
        tick(1'b0, 4'b0000, 1'b1, 8'h00, 16'h0000, 1'b1, 12'h000, "t2_en");
        dmas_cnt  = 0;
        int_cnt   = 0;
        dmal_cnt  = 0;
        first_idx = -1;
        last_idx  = -1;
        for (int i = 0; i < 65537; i++) begin
            bus.strhor  = 1'b1;
            bus.datreq  = 4'b0010;
            bus.clk7_en = 1'b1;
            @(posedge clk);
            #1;
            if (bus.audio_dmal[1]) dmal_cnt++;
            if (bus.audint[1]) int_cnt++;
            if (bus.audio_dmas[1]) begin
                dmas_cnt++;
                if (first_idx < 0) first_idx = i;
                last_idx = i;
            end
        end
        bus.strhor  = 1'b0;
        bus.datreq  = 4'b0000;
        bus.clk7_en = 1'b0;
        check_eq("t2_dmal_cnt",  dmal_cnt,  65537);
        check_eq("t2_dmas_cnt",  dmas_cnt,  2);
        check_eq("t2_dmas_first", first_idx, 0);
        check_eq("t2_dmas_last", last_idx,  65536);
        check_eq("t2_int_cnt",   int_cnt,   2);
        check_eq("t2_others",    {28'd0, bus.audio_dmal & 4'b1101}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
